// File: rtl/match_pkg.sv
// match_pkg: shared widths and FSM state encoding for the match scan block.
package match_pkg;
  localparam int MATCH_ADDR_WIDTH = 4;
  localparam int MATCH_DATA_WIDTH = 32;
  localparam int MATCH_DEPTH      = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/match_compare.sv
// match_compare: masked equality of a memory word against a key.
module match_compare
  import match_pkg::*;
#(
  parameter int W = MATCH_DATA_WIDTH
) (
  input  logic [W-1:0] key_i,
  input  logic [W-1:0] mask_i,
  input  logic [W-1:0] word_i,
  output logic         hit_o
);
  assign hit_o = ((word_i ^ key_i) & mask_i) == '0;
endmodule

// File: rtl/match_scan_controller.sv
// match_scan_controller: walks every SRAM address once, counting masked key
// matches and recording the lowest matching address.
module match_scan_controller
  import match_pkg::*;
#(
  parameter int ADDR_WIDTH = MATCH_ADDR_WIDTH,
  parameter int DATA_WIDTH = MATCH_DATA_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] SearchKey,
  input  logic [DATA_WIDTH-1:0] SearchMask,
  input  logic                  StopOnFirst,
  output logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] MemData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Found,
  output logic [ADDR_WIDTH-1:0] MatchAddress,
  output logic [ADDR_WIDTH:0]   MatchCount
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] key_q, key_d, mask_q, mask_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  sof_q, sof_d, found_q, found_d, hit;
  match_compare #(.W(DATA_WIDTH)) u_cmp (
    .key_i (key_q),
    .mask_i(mask_q),
    .word_i(MemData),
    .hit_o (hit)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    maddr_d = maddr_q;
    key_d   = key_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    sof_d   = sof_q;
    found_d = found_q;
    if (state_q == IDLE && Start) begin
      state_d = SCAN;
      key_d   = SearchKey;
      mask_d  = SearchMask;
      sof_d   = StopOnFirst;
      addr_d  = '0;
      maddr_d = '0;
      cnt_d   = '0;
      found_d = 1'b0;
    end else if (state_q == SCAN) begin
      if (hit) begin
        cnt_d   = cnt_q + 1'b1;
        found_d = 1'b1;
        maddr_d = found_q ? maddr_q : addr_q;
      end
      // Last address always terminates; the counter never wraps inside a scan.
      if (&addr_q || (hit && sof_q)) state_d = DONE;
      else addr_d = addr_q + 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      maddr_q <= '0;
      key_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      sof_q   <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      sof_q   <= sof_d;
      found_q <= found_d;
    end
  end
  assign Address      = (state_q == SCAN) ? addr_q : '0;
  assign Busy         = state_q != IDLE;
  assign Done         = state_q == DONE;
  assign Found        = found_q;
  assign MatchAddress = maddr_q;
  assign MatchCount   = cnt_q;
endmodule

// File: doc/match_scan_controller.md
# match_scan_controller

Sequencer that scans the 16-entry x 32-bit match memory (SRAM, combinational read) for a search key. It drives the SRAM address port, compares each returned word against a masked key, and reports the first matching address and the total match count. It sits between the host/command logic and the SRAM instance, and is the only driver of the SRAM `Address` bus.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: SRAM address width; depth = 2^ADDR_WIDTH (16).
- `DATA_WIDTH`, default 32: SRAM word width.

Ports (one clock; reset is synchronous and active-high):
- `Clock`  in  1  rising-edge clock for all state.
- `Reset`  in  1  synchronous, active-high; returns the block to IDLE.
- `Start`  in  1  request a scan; sampled only in IDLE.
- `SearchKey`  in  DATA_WIDTH  key; latched on accepted Start.
- `SearchMask`  in  DATA_WIDTH  1 = bit compared; latched on accepted Start.
- `StopOnFirst`  in  1  1 = end the scan at the first match; latched on accepted Start.
- `Address`  out  ADDR_WIDTH  to SRAM address.
- `MemData`  in  DATA_WIDTH  from SRAM data; valid in the same cycle as `Address`.
- `Busy`  out  1  high in SCAN and DONE.
- `Done`  out  1  one-cycle pulse when results are final.
- `Found`  out  1  at least one match in the last scan.
- `MatchAddress`  out  ADDR_WIDTH  lowest matching address; 0 if none.
- `MatchCount`  out  ADDR_WIDTH+1  number of matches, 0..16.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE, Start=1: latch key, mask and StopOnFirst. Clear the address counter, Found, MatchAddress and MatchCount. Go to SCAN.
- IDLE, Start=0: hold. Results from the previous scan stay stable.
- SCAN: `Address` = counter. Each cycle evaluates hit = ((MemData ^ key) & mask) == 0.
  - On a hit: MatchCount += 1. If Found was 0, set Found=1 and MatchAddress=counter.
- SCAN exit:
  - To DONE after the cycle where counter = 15.
  - Also to DONE after the first hit when StopOnFirst=1. MatchCount is then 1.
  - Otherwise the counter increments.
- DONE: `Done`=1 for exactly one cycle, then go to IDLE.
- Start while Busy is ignored. A new scan is not queued.
- Mask = 0 matches every word: MatchCount = 16, MatchAddress = 0. With StopOnFirst=1, MatchCount = 1.
- MatchCount width is ADDR_WIDTH+1 so that 16 does not wrap.
- The counter does not wrap in SCAN. Reaching 15 always ends the scan.
- `Address` holds 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, Address=0, Busy=0, Done=0, Found=0, MatchAddress=0, MatchCount=0, latched key/mask/StopOnFirst=0.
- Reset has priority over every other input, including mid-SCAN. The scan is abandoned with no Done pulse.
- Start is sampled at edge E (state IDLE). SCAN occupies cycles E+1..E+16, with Address k during cycle E+1+k.
- Full scan: Done is high in cycle E+17, and Busy is high in cycles E+1..E+17.
- Early stop at a hit on address k: Done is high in cycle E+k+2.
- Found, MatchAddress and MatchCount are registered. They are final and stable when Done is high, and stay stable until the next accepted Start.
- Start high in the Done cycle is ignored. Start high in the following IDLE cycle is accepted, giving back-to-back scans every 18 cycles.
- MemData is sampled at the end of each SCAN cycle. The SRAM access time must be less than one clock period.

## Structure
- Package `match_pkg`:
  - State enum: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - Constants MATCH_ADDR_WIDTH=4, MATCH_DATA_WIDTH=32, MATCH_DEPTH=16.
- Sub-module `match_compare`: combinational masked equality (key, mask, word) -> hit. It is reused by a future multi-port arbiter.
- Top level: FSM, address counter, result registers.
- Bench instantiates this block with the existing SRAM module and loads the memory via $readmemh.

## Test plan
- Reset clears everything: memory loaded, Reset held 2 cycles mid-SCAN -> Busy=0, Done never pulses, all outputs 0 on the next cycle.
- Full scan with two hits: mem[5]=mem[9]=32'hDEADBEEF, others distinct; key 32'hDEADBEEF, mask 32'hFFFFFFFF, StopOnFirst=0 -> Done at E+17, Found=1, MatchAddress=5, MatchCount=2.
- Early stop: same memory, StopOnFirst=1 -> Done at E+7, MatchAddress=5, MatchCount=1, Address sequence 0..5 only.
- Miss and masking, run as two scans on the same memory:
  - Key 32'h12345678 with full mask, no such word -> Found=0, MatchAddress=0, MatchCount=0.
  - Mask 32'h00000000 -> MatchCount=16 with no overflow, MatchAddress=0.
- Start handling:
  - Start pulsed during SCAN and on the Done cycle -> ignored; the results and the 17-cycle latency are unchanged.
  - Start in the next IDLE cycle -> the second scan begins.
  - SearchKey changed mid-scan -> no effect on the result.
